// File: rtl/calc_sequencer.sv
// calc_sequencer: key-entry and operation sequencer owning the display (entry) and accumulator registers.
// Latency: a key accepted at edge T updates state after T; an ALU-issuing key raises alu_req_o from T+1; the result lands after the ack edge.
// Backpressure: key_ready_o is low while an ALU request is outstanding; in ERROR every key except AC is accepted and dropped.
// Ports: clk_i/rst_ni clock and async active-low reset; key_valid_i/key_code_i/key_ready_o key stream;
//   disp_*_o and acc_*_o display and accumulator; alu_req_o/alu_op_o/alu_left_o/alu_right_o/alu_ack_i/
//   alu_result_i/alu_err_i multi-cycle ALU handshake; error_o sticky error. Number bundles are packed {sign, digits, exp}.
module calc_sequencer #(
  parameter int NumDigits = 8,
  parameter int ExpW      = $clog2(NumDigits) + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      key_valid_i,
  input  logic [4:0]                key_code_i,
  output logic                      key_ready_o,
  output logic                      disp_sign_o,
  output logic [4*NumDigits-1:0]    disp_digits_o,
  output logic [ExpW-1:0]           disp_exp_o,
  output logic                      acc_sign_o,
  output logic [4*NumDigits-1:0]    acc_digits_o,
  output logic [ExpW-1:0]           acc_exp_o,
  output logic                      alu_req_o,
  output logic [1:0]                alu_op_o,
  output logic [4*NumDigits+ExpW:0] alu_left_o,
  output logic [4*NumDigits+ExpW:0] alu_right_o,
  input  logic                      alu_ack_i,
  input  logic [4*NumDigits+ExpW:0] alu_result_i,
  input  logic                      alu_err_i,
  output logic                      error_o
);

  localparam int DW   = 4 * NumDigits;
  localparam int CntW = $clog2(NumDigits + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(NumDigits);

  typedef struct packed {
    logic            sign;
    logic [DW-1:0]   digits;
    logic [ExpW-1:0] exp;
  } num_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_ALU, S_ERROR} state_e;

  state_e          state_q;
  num_t            disp_q, acc_q, last_q, alu_left_q, alu_right_q;
  logic [1:0]      alu_op_q, pend_op_q, last_op_q;
  logic            key_ready_q, alu_req_q, error_q;
  logic            fresh_q, dot_q, pending_q, repeat_q;
  logic [CntW-1:0] count_q, frac_q;

  logic            key_fire, is_digit, is_op, is_eq, clear_all;
  logic            iss_vld;
  num_t            iss_l, iss_r, alu_res;
  logic [1:0]      iss_op;

  assign alu_res   = alu_result_i;
  assign key_fire  = key_valid_i && key_ready_q;
  assign is_digit  = (key_code_i <= 5'd9);
  assign is_op     = (key_code_i >= 5'd11) && (key_code_i <= 5'd14);
  assign is_eq     = (key_code_i == 5'd15);
  assign clear_all = key_fire && (key_code_i == 5'd19);

  function automatic logic [DW-1:0] put_nib(input logic [DW-1:0] v, input logic [CntW-1:0] pos,
                                            input logic [3:0] nib);
    logic [DW-1:0] r;
    r = v;
    r[4*pos +: 4] = nib;
    return r;
  endfunction

  // Decide whether the key being accepted starts an ALU operation, and with which operands.
  always_comb begin
    iss_vld = 1'b0;
    iss_l   = acc_q;
    iss_r   = disp_q;
    iss_op  = pend_op_q;
    if (key_fire && state_q == S_IDLE) begin
      if (is_op && pending_q && !fresh_q) begin
        iss_vld = 1'b1;
      end else if (is_eq && pending_q) begin
        iss_vld = 1'b1;
      end else if (is_eq && repeat_q) begin
        iss_vld = 1'b1;
        iss_l   = disp_q;
        iss_r   = last_q;
        iss_op  = last_op_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;  disp_q <= '0;  acc_q <= '0;  last_q <= '0;
      alu_left_q <= '0;  alu_right_q <= '0;  alu_op_q <= '0;  pend_op_q <= '0;  last_op_q <= '0;
      key_ready_q <= 1'b1;  alu_req_q <= 1'b0;  error_q <= 1'b0;
      fresh_q <= 1'b1;  dot_q <= 1'b0;  pending_q <= 1'b0;  repeat_q <= 1'b0;
      count_q <= '0;  frac_q <= '0;
    end else if (clear_all) begin
      state_q <= S_IDLE;  disp_q <= '0;  acc_q <= '0;  last_q <= '0;
      alu_left_q <= '0;  alu_right_q <= '0;  alu_op_q <= '0;  pend_op_q <= '0;  last_op_q <= '0;
      key_ready_q <= 1'b1;  alu_req_q <= 1'b0;  error_q <= 1'b0;
      fresh_q <= 1'b1;  dot_q <= 1'b0;  pending_q <= 1'b0;  repeat_q <= 1'b0;
      count_q <= '0;  frac_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (key_fire) begin
          if (iss_vld) begin
            alu_left_q  <= iss_l;
            alu_right_q <= iss_r;
            alu_op_q    <= iss_op;
            alu_req_q   <= 1'b1;
            key_ready_q <= 1'b0;
            state_q     <= S_WAIT_ALU;
          end
          if (is_digit) begin
            if (fresh_q) begin
              // A leading zero leaves the entry fresh so it never occupies a digit slot.
              if (key_code_i != 5'd0) begin
                disp_q  <= {1'b0, put_nib('0, CntMax - 1'b1, key_code_i[3:0]), {ExpW{1'b0}}};
                count_q <= CntW'(1);
                fresh_q <= 1'b0;
              end else begin
                disp_q <= '0;
              end
            end else if (count_q != CntMax) begin
              disp_q.digits <= put_nib(disp_q.digits, CntMax - 1'b1 - count_q, key_code_i[3:0]);
              count_q <= count_q + 1'b1;
              if (dot_q) frac_q <= frac_q + 1'b1;
              else       disp_q.exp <= disp_q.exp + 1'b1;
            end
          end else if (is_op || is_eq) begin
            if (is_op) begin
              if (!pending_q) acc_q <= disp_q;
              pend_op_q <= 2'(key_code_i - 5'd11);
              pending_q <= 1'b1;
              repeat_q  <= 1'b0;
            end else if (pending_q) begin
              last_q    <= disp_q;
              last_op_q <= pend_op_q;
              pending_q <= 1'b0;
              repeat_q  <= 1'b1;
            end
            fresh_q <= 1'b1;
            count_q <= '0;
            dot_q   <= 1'b0;
            frac_q  <= '0;
          end else begin
            case (key_code_i)
              5'd10: if (!dot_q) begin
                if (fresh_q) begin
                  disp_q  <= '0;
                  count_q <= CntW'(1);
                  fresh_q <= 1'b0;
                end
                dot_q <= 1'b1;
              end
              5'd16: disp_q.sign <= ~disp_q.sign;
              5'd17: if (!fresh_q) begin
                if (frac_q != '0) begin
                  disp_q.digits <= put_nib(disp_q.digits, CntMax - count_q, 4'd0);
                  count_q <= count_q - 1'b1;
                  frac_q  <= frac_q - 1'b1;
                end else if (dot_q) begin
                  dot_q <= 1'b0;
                end else begin
                  disp_q.digits <= put_nib(disp_q.digits, CntMax - count_q, 4'd0);
                  count_q <= count_q - 1'b1;
                  if (disp_q.exp != '0) disp_q.exp <= disp_q.exp - 1'b1;
                end
                // Removing the last remaining digit returns the entry to the fresh state.
                if (count_q == CntW'(1) && !(dot_q && frac_q == '0)) begin
                  disp_q  <= '0;
                  fresh_q <= 1'b1;
                  count_q <= '0;
                  dot_q   <= 1'b0;
                  frac_q  <= '0;
                end
              end
              5'd18: begin
                disp_q  <= '0;
                fresh_q <= 1'b1;
                count_q <= '0;
                dot_q   <= 1'b0;
                frac_q  <= '0;
              end
              default: ;
            endcase
          end
        end
        S_WAIT_ALU: if (alu_ack_i) begin
          alu_req_q   <= 1'b0;
          key_ready_q <= 1'b1;
          if (alu_err_i) begin
            disp_q  <= '0;
            error_q <= 1'b1;
            state_q <= S_ERROR;
          end else begin
            disp_q  <= alu_res;
            acc_q   <= alu_res;
            state_q <= S_IDLE;
          end
        end
        S_ERROR: ;  // only AC leaves, handled above
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign key_ready_o   = key_ready_q;
  assign disp_sign_o   = disp_q.sign;
  assign disp_digits_o = disp_q.digits;
  assign disp_exp_o    = disp_q.exp;
  assign acc_sign_o    = acc_q.sign;
  assign acc_digits_o  = acc_q.digits;
  assign acc_exp_o     = acc_q.exp;
  assign alu_req_o     = alu_req_q;
  assign alu_op_o      = alu_op_q;
  assign alu_left_o    = alu_left_q;
  assign alu_right_o   = alu_right_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed key sequences against calc_sequencer with NumDigits=4, bench acting as the ALU.
// Latency: outputs are checked 1ns after the clock edge that accepted each key or ack.
// Backpressure: keys are only pressed while the sequencer is idle or in error.
module tb_calc_sequencer;

  localparam int N  = 4;
  localparam int EW = 3;
  localparam int NW = 4 * N + EW + 1;

  logic          clk, rst_n;
  logic          key_valid;
  logic [4:0]    key_code;
  logic          key_ready;
  logic          disp_sign, acc_sign;
  logic [4*N-1:0] disp_digits, acc_digits;
  logic [EW-1:0] disp_exp, acc_exp;
  logic          alu_req;
  logic [1:0]    alu_op;
  logic [NW-1:0] alu_left, alu_right, alu_result;
  logic          alu_ack, alu_err, error_flag;

  int tests  = 0;
  int failed = 0;
  int req_cnt = 0;
  logic req_prev = 1'b0;
  int cnt0;

  calc_sequencer #(.NumDigits(N), .ExpW(EW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .key_valid_i(key_valid), .key_code_i(key_code), .key_ready_o(key_ready),
    .disp_sign_o(disp_sign), .disp_digits_o(disp_digits), .disp_exp_o(disp_exp),
    .acc_sign_o(acc_sign), .acc_digits_o(acc_digits), .acc_exp_o(acc_exp),
    .alu_req_o(alu_req), .alu_op_o(alu_op), .alu_left_o(alu_left), .alu_right_o(alu_right),
    .alu_ack_i(alu_ack), .alu_result_i(alu_result), .alu_err_i(alu_err),
    .error_o(error_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count distinct ALU requests (rising edges of alu_req_o).
  always @(posedge clk) begin
    if (alu_req && !req_prev) req_cnt <= req_cnt + 1;
    req_prev <= alu_req;
  end

  function automatic logic [NW-1:0] num(input logic s, input logic [15:0] d, input logic [EW-1:0] e);
    return {s, d, e};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [4:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic chk_disp(input string tag, input logic s, input logic [15:0] d, input logic [EW-1:0] e);
    chk({tag, "_sign"}, 32'(disp_sign), 32'(s));
    chk({tag, "_dig"}, 32'(disp_digits), 32'(d));
    chk({tag, "_exp"}, 32'(disp_exp), 32'(e));
  endtask

  // Act as the ALU: expect the request for lat cycles, then ack on the last of them.
  task automatic alu_reply(input int lat, input logic [NW-1:0] exp_l, input logic [NW-1:0] res,
                           input logic err);
    for (int c = 1; c <= lat; c++) begin
      chk("req_hi", 32'(alu_req), 32'd1);
      chk("rdy_lo", 32'(key_ready), 32'd0);
      chk("left_stable", 32'(alu_left), 32'(exp_l));
      if (c == lat) begin
        @(negedge clk);
        alu_ack    = 1'b1;
        alu_result = res;
        alu_err    = err;
        @(posedge clk);
        #1;
        alu_ack = 1'b0;
        alu_err = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    chk("req_drop", 32'(alu_req), 32'd0);
    chk("rdy_back", 32'(key_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;  key_valid = 1'b0;  key_code = '0;
    alu_ack = 1'b0;  alu_err = 1'b0;  alu_result = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_ready", 32'(key_ready), 32'd1);
    chk("rst_req", 32'(alu_req), 32'd0);
    chk("rst_err", 32'(error_flag), 32'd0);
    chk("rst_left", 32'(alu_left), 32'd0);
    chk("rst_acc", 32'(acc_digits), 32'd0);
    chk_disp("rst_disp", 1'b0, 16'h0000, 3'd0);

    // Entry with a fractional part and the digit-count limit
    press(5'd1); press(5'd2); press(5'd10); press(5'd5);
    chk_disp("e125", 1'b0, 16'h1250, 3'd1);
    press(5'd7);
    chk_disp("e1257", 1'b0, 16'h1257, 3'd1);
    press(5'd9);
    chk_disp("e_full", 1'b0, 16'h1257, 3'd1);
    press(5'd19);

    // Leading zeros, backspace over the dot, backspace to empty
    press(5'd0); press(5'd0);
    chk_disp("lead0", 1'b0, 16'h0000, 3'd0);
    press(5'd7);
    chk_disp("e007", 1'b0, 16'h7000, 3'd0);
    press(5'd19);
    press(5'd1); press(5'd10); press(5'd17); press(5'd3);
    chk_disp("bs_dot", 1'b0, 16'h1300, 3'd1);
    press(5'd19);
    press(5'd1); press(5'd2); press(5'd17);
    chk_disp("bs_one", 1'b0, 16'h1000, 3'd0);
    press(5'd17);
    chk_disp("bs_empty", 1'b0, 16'h0000, 3'd0);
    press(5'd4);
    chk_disp("after_empty", 1'b0, 16'h4000, 3'd0);
    press(5'd16);
    chk("neg_on", 32'(disp_sign), 32'd1);
    press(5'd16);
    chk("neg_off", 32'(disp_sign), 32'd0);
    press(5'd19);

    // 2 + 3 = with a 3-cycle ALU, then repeated equals with a 1-cycle ALU
    press(5'd2); press(5'd11);
    chk("acc_2", 32'(acc_digits), 32'h2000);
    press(5'd3); press(5'd15);
    chk("add_left", 32'(alu_left), 32'(num(1'b0, 16'h2000, 3'd0)));
    chk("add_right", 32'(alu_right), 32'(num(1'b0, 16'h3000, 3'd0)));
    chk("add_op", 32'(alu_op), 32'd0);
    alu_reply(3, num(1'b0, 16'h2000, 3'd0), num(1'b0, 16'h5000, 3'd0), 1'b0);
    chk_disp("res5", 1'b0, 16'h5000, 3'd0);
    chk("acc5", 32'(acc_digits), 32'h5000);
    press(5'd15);
    chk("rep_left", 32'(alu_left), 32'(num(1'b0, 16'h5000, 3'd0)));
    chk("rep_right", 32'(alu_right), 32'(num(1'b0, 16'h3000, 3'd0)));
    alu_reply(1, num(1'b0, 16'h5000, 3'd0), num(1'b0, 16'h8000, 3'd0), 1'b0);
    chk_disp("res8", 1'b0, 16'h8000, 3'd0);
    press(5'd19);

    // 6 + * 2 = : the second operator only replaces the pending one
    cnt0 = req_cnt;
    press(5'd6); press(5'd11); press(5'd13);
    chk("op_replace_noreq", 32'(alu_req), 32'd0);
    press(5'd2); press(5'd15);
    chk("mul_op", 32'(alu_op), 32'd2);
    chk("mul_left", 32'(alu_left), 32'(num(1'b0, 16'h6000, 3'd0)));
    chk("mul_right", 32'(alu_right), 32'(num(1'b0, 16'h2000, 3'd0)));
    alu_reply(2, num(1'b0, 16'h6000, 3'd0), num(1'b0, 16'h1200, 3'd1), 1'b0);
    chk("one_request", 32'(req_cnt - cnt0), 32'd1);
    chk_disp("res12", 1'b0, 16'h1200, 3'd1);
    press(5'd19);

    // 9 / 0 = with an ALU error
    press(5'd9); press(5'd14); press(5'd0); press(5'd15);
    chk("div_op", 32'(alu_op), 32'd3);
    chk("div_right", 32'(alu_right), 32'd0);
    alu_reply(2, num(1'b0, 16'h9000, 3'd0), num(1'b0, 16'h1111, 3'd0), 1'b1);
    chk("err_set", 32'(error_flag), 32'd1);
    chk_disp("err_disp", 1'b0, 16'h0000, 3'd0);
    press(5'd5);
    chk_disp("err_drop", 1'b0, 16'h0000, 3'd0);
    chk("err_sticky", 32'(error_flag), 32'd1);
    press(5'd19);
    chk("ac_err", 32'(error_flag), 32'd0);
    chk("ac_acc", 32'(acc_digits), 32'd0);
    chk("ac_ready", 32'(key_ready), 32'd1);
    press(5'd3);
    chk_disp("ac_idle", 1'b0, 16'h3000, 3'd0);
    press(5'd19);

    // Asynchronous reset while a request is outstanding
    press(5'd4); press(5'd11); press(5'd1); press(5'd15);
    chk("pre_rst_req", 32'(alu_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req", 32'(alu_req), 32'd0);
    chk("async_ready", 32'(key_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    alu_ack    = 1'b1;
    alu_result = num(1'b0, 16'h5000, 3'd0);
    @(posedge clk); #1;
    alu_ack = 1'b0;
    chk_disp("late_ack", 1'b0, 16'h0000, 3'd0);
    chk("late_acc", 32'(acc_digits), 32'd0);
    chk("late_req", 32'(alu_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Parametrised key-entry and operation sequencer for the calculator datapath. It replaces the fixed-width controller. It owns the display (entry) and accumulator registers internally. It accepts keys over a valid/ready handshake and drives a multi-cycle ALU through a req/ack handshake. Compared with the fixed-width controller, it adds backspace, sign toggle, clear-entry, all-clear, repeated equals and error handling.

## Interface
- NumDigits, 8: BCD digits per number (≥2).
- ExpW, $clog2(NumDigits)+1: exponent width.
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  asynchronous, active-low reset.
- key_valid_i  in  1  key present.
- key_code_i  in  5  key code: 0–9 digit; 10 dot; 11 add; 12 sub; 13 mul; 14 div; 15 eq; 16 neg; 17 backspace; 18 CE; 19 AC; other codes are accepted and dropped.
- key_ready_o  out  1  key accepted on a cycle where key_valid_i && key_ready_o.
- disp_sign_o / disp_digits_o / disp_exp_o  out  1 / 4*NumDigits / ExpW  display value.
- acc_sign_o / acc_digits_o / acc_exp_o  out  1 / 4*NumDigits / ExpW  accumulator.
- alu_req_o  out  1  ALU request.
- alu_op_o  out  2  ALU opcode: 0 add, 1 sub, 2 mul, 3 div.
- alu_left_o / alu_right_o  out  number bundle  ALU operands (sign, digits, exp).
- alu_ack_i  in  1  result valid.
- alu_result_i  in  number bundle  ALU result.
- alu_err_i  in  1  result invalid (e.g. divide by zero); qualified by alu_ack_i.
- error_o  out  1  sticky error flag.

## Operation
- Number format: value = sign × d[N-1].d[N-2]…d[0] × 10^exp; d[N-1] is the top nibble.
- Entry state: fresh, count (0..NumDigits), dot_seen, frac (digits entered after the dot).
- Digit key:
  - fresh, digit 0, no dot: display ← 0, stays fresh (leading-zero suppression).
  - fresh, otherwise: display ← 0 with the digit at d[N-1]; count=1, exp=0, fresh=0.
  - not fresh, count<N: write d[N-1-count]; count++; exp += !dot_seen; frac += dot_seen.
  - count==N: ignored.
- Dot key:
  - dot_seen: ignored.
  - fresh: display ← 0, count=1, fresh=0.
  - Then dot_seen=1.
- Backspace (ignored when fresh), first matching rule only:
  - frac>0: clear the last digit; count--, frac--.
  - dot_seen with frac==0: dot_seen=0, no digit cleared.
  - otherwise: clear d[N-count]; count--; exp-- if exp>0.
  - When count reaches 0: display ← 0, fresh=1.
- Neg: toggles disp_sign; does not change fresh.
- CE: display ← 0, fresh=1, count/dot_seen/frac cleared; accumulator and pending op kept.
- AC: all state returns to reset values, including error_o.
- Op key, first matching rule only:
  - pending && !fresh: issue ALU(acc, display, pending_op); result → display and acc.
  - pending && fresh: replace pending_op only, no ALU request.
  - otherwise: acc ← display.
  - Then pending_op ← key, pending=1, fresh=1, repeat_valid=0.
- Eq key, first matching rule only:
  - pending: last_operand ← display; issue ALU(acc, display, pending_op); result → display and acc; pending=0, repeat_valid=1.
  - repeat_valid: issue ALU(display, last_operand, last_op); result → display and acc.
  - otherwise: no action.
  - Then fresh=1.
- States:
  - IDLE: key_ready_o=1.
  - WAIT_ALU: key_ready_o=0; alu_req_o=1.
  - ERROR: key_ready_o=1; all keys except AC dropped.
- Transitions:
  - IDLE → WAIT_ALU on an accepted key that issues an ALU request.
  - WAIT_ALU → IDLE on alu_ack_i && !alu_err_i.
  - WAIT_ALU → ERROR on alu_ack_i && alu_err_i; display ← 0, error_o=1.
  - ERROR → IDLE on AC.

## Timing
- All outputs are registered.
- Reset values: display and acc zero with sign 0 and exp 0; alu_req_o=0; alu_op_o=0; operands zero; error_o=0; key_ready_o=1; fresh=1; pending=0; repeat_valid=0.
- Key accepted at edge T: display and state are updated after T (1-cycle latency).
- ALU-issuing key accepted at edge T: from the cycle after T, alu_req_o=1 and key_ready_o=0.
  - Operands and opcode are stable while alu_req_o is high.
  - alu_ack_i is sampled only while alu_req_o=1; an ack in the first request cycle is legal.
  - Ack sampled at edge A: result is written and alu_req_o drops after A; key_ready_o=1 in the cycle after A.
  - Minimum key-to-result latency is 2 cycles.
- alu_ack_i is ignored outside WAIT_ALU.
- Asynchronous reset mid-request: alu_req_o drops immediately; the late ack is ignored.

## Test plan
- NumDigits=4, keys 1,2,.,5 → digits 1250, exp=1, sign 0; then key 7 → 1257; then key 9 → ignored (count=4).
- Keys 0,0,7 → digits 7000, exp 0; keys 1,.,backspace,3 → digits 1300, exp 1; keys 1,2,backspace,backspace → display zero and fresh.
- Keys 2,+,3,= with ack 3 cycles after request, result 5 → alu_req_o high 3 cycles with left 2, right 3, op 0; key_ready_o low for those 3 cycles; display 5. Key = again → request with left 5, right 3 → display 8.
- Keys 6,+,*,2,= → exactly one ALU request: op 2, left 6, right 2.
- Keys 9,/,0,= with ack plus alu_err_i → error_o=1 and display 0; key 5 is accepted and dropped; AC → error_o=0 and all reset values restored.
- rst_ni pulsed low while alu_req_o=1 → alu_req_o=0 asynchronously; an ack arriving after reset release changes nothing.
